pll_reconfig_ctrl: RTL and testbench

PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

---
 rtl/pll_cfg_pkg.sv | 34 +++
 rtl/sync_2ff.sv | 24 ++
 rtl/pll_reconfig_ctrl.sv | 120 ++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_cfg_pkg.sv
// Shared types and constants for the PLL dynamic-reconfiguration controller.
package pll_cfg_pkg;

    localparam int ODIV_W  = 10;
    localparam int DUTY_W  = 10;
    localparam int PHASE_W = 13;

    localparam logic [ODIV_W-1:0]  ODIV_RST  = 10'd100;
    localparam logic [DUTY_W-1:0]  DUTY_RST  = 10'd100;
    localparam logic [PHASE_W-1:0] PHASE_RST = 13'd16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_WAIT_LOCK,
        S_DONE,
        S_ERR
    } state_e;

    typedef struct packed {
        logic [ODIV_W-1:0]  odiv;
        logic [DUTY_W-1:0]  duty;
        logic [PHASE_W-1:0] phase;
    } cfg_t;

    localparam cfg_t CFG_RST = '{odiv: ODIV_RST, duty: DUTY_RST, phase: PHASE_RST};

    // Duty is expressed in half-steps of the output divider, so it may reach 2*odiv.
    function automatic logic cfg_legal(input logic [ODIV_W-1:0] odiv,
                                       input logic [DUTY_W-1:0] duty);
        return (odiv != '0) && ({1'b0, duty} <= {odiv, 1'b0});
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
    input  logic clk_tb,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration sequencer: load settings, pulse PLL reset, wait for stable lock.
// Define PLL_LOCK_TIMEOUT_EN to bound the lock wait by TIMEOUT_CYCLES.
module pll_reconfig_ctrl
    import pll_cfg_pkg::*;
#(
    parameter int RST_CYCLES         = 10,
    parameter int LOCK_STABLE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES     = 65535
) (
    input  logic               clk_tb,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ODIV_W-1:0]  req_odiv,
    input  logic [DUTY_W-1:0]  req_duty,
    input  logic [PHASE_W-1:0] req_phase,
    input  logic               pll_lock,
    output logic               pll_rst,
    output logic [ODIV_W-1:0]  dyn_odiv0,
    output logic [DUTY_W-1:0]  dyn_duty0,
    output logic [PHASE_W-1:0] dyn_phase0,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               lock_lost
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int SC_W = $clog2(LOCK_STABLE_CYCLES + 1);

    state_e          state_q, state_d;
    logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [SC_W-1:0] stable_cnt_q, stable_cnt_d;
    cfg_t            dyn_q, dyn_d;
    logic            lock_s, lock_prev_q, locked_once_q, locked_once_d;
    logic            cfg_ok, stable_hit, to_hit;

    sync_2ff u_lock_sync (
        .clk_tb (clk_tb),
        .rst_n  (rst_n),
        .d      (pll_lock),
        .q      (lock_s)
    );

    assign cfg_ok = cfg_legal(req_odiv, req_duty);

    // Counters clear outside their state, so they never exceed their parameter.
    always_comb begin
        rst_cnt_d     = (state_q == S_RST) ? rst_cnt_q + 1'b1 : '0;
        stable_cnt_d  = (state_q == S_WAIT_LOCK && lock_s) ? stable_cnt_q + 1'b1 : '0;
        stable_hit    = (stable_cnt_d == SC_W'(LOCK_STABLE_CYCLES));
        locked_once_d = locked_once_q | (state_q == S_DONE);
        dyn_d         = dyn_q;
        if (state_q == S_IDLE && req_valid && cfg_ok)
            dyn_d = '{odiv: req_odiv, duty: req_duty, phase: req_phase};
    end

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam int TC_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TC_W-1:0] to_cnt_q, to_cnt_d;

    assign to_cnt_d = (state_q == S_WAIT_LOCK) ? to_cnt_q + 1'b1 : '0;
    assign to_hit   = (to_cnt_d == TC_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk_tb or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rst_cnt_q     <= '0;
            stable_cnt_q  <= '0;
            dyn_q         <= CFG_RST;
            lock_prev_q   <= 1'b0;
            locked_once_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            stable_cnt_q  <= stable_cnt_d;
            dyn_q         <= dyn_d;
            lock_prev_q   <= lock_s;
            locked_once_q <= locked_once_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (req_valid) state_d = cfg_ok ? S_RST : S_ERR;
            S_RST:       if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                // A lock completing on the timeout cycle still counts as success.
                if (stable_hit)  state_d = S_DONE;
                else if (to_hit) state_d = S_ERR;
            end
            S_DONE:      state_d = S_IDLE;
            S_ERR:       state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        pll_rst   = (state_q == S_RST);
        done      = (state_q == S_DONE);
        err       = (state_q == S_ERR);
        lock_lost = (state_q == S_IDLE) && locked_once_q && lock_prev_q && !lock_s;
    end

    assign dyn_odiv0  = dyn_q.odiv;
    assign dyn_duty0  = dyn_q.duty;
    assign dyn_phase0 = dyn_q.phase;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Scoreboard bench for pll_reconfig_ctrl: directed requests, a behavioural lock model,
// and a monitor that checks every done/err/lock_lost pulse against queued expectations.
module tb_pll_reconfig_ctrl;
    import pll_cfg_pkg::*;

    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;
    localparam int K_LOST = 4;

    logic               clk_tb = 1'b0;
    logic               rst_n = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [ODIV_W-1:0]  req_odiv = '0;
    logic [DUTY_W-1:0]  req_duty = '0;
    logic [PHASE_W-1:0] req_phase = '0;
    logic               pll_lock = 1'b0;
    logic               pll_rst;
    logic [ODIV_W-1:0]  dyn_odiv0;
    logic [DUTY_W-1:0]  dyn_duty0;
    logic [PHASE_W-1:0] dyn_phase0;
    logic               busy, done, err, lock_lost;

    always #5 clk_tb = ~clk_tb;

    pll_reconfig_ctrl #(
        .RST_CYCLES         (10),
        .LOCK_STABLE_CYCLES (4),
        .TIMEOUT_CYCLES     (100)
    ) dut (
        .clk_tb     (clk_tb),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_odiv   (req_odiv),
        .req_duty   (req_duty),
        .req_phase  (req_phase),
        .pll_lock   (pll_lock),
        .pll_rst    (pll_rst),
        .dyn_odiv0  (dyn_odiv0),
        .dyn_duty0  (dyn_duty0),
        .dyn_phase0 (dyn_phase0),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .lock_lost  (lock_lost)
    );

    // lat_src: 0 = no latency check, 1 = cycles since acceptance, 2 = cycles since pll_rst fell
    typedef struct {
        int kind;
        int odiv;
        int duty;
        int phase;
        int rst_len;
        int lat_src;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   lock_mode = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic push(input int kind, input int odiv, input int duty, input int phase,
                        input int rst_len, input int lat_src, input int lat);
        exp_t e;
        e.kind = kind; e.odiv = odiv; e.duty = duty; e.phase = phase;
        e.rst_len = rst_len; e.lat_src = lat_src; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic send(input int odiv, input int duty, input int phase);
        @(posedge clk_tb); #1;
        req_valid = 1'b1;
        req_odiv  = ODIV_W'(odiv);
        req_duty  = DUTY_W'(duty);
        req_phase = PHASE_W'(phase);
        @(posedge clk_tb); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(posedge clk_tb);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 0);
        repeat (3) @(posedge clk_tb);
    endtask

    // Lock model: the PLL drops lock when reset rises and relocks per lock_mode.
    initial begin : lock_model
        forever begin
            @(posedge pll_rst);
            pll_lock = 1'b0;
            @(negedge pll_rst);
            if (lock_mode == 0) begin
                repeat (50) @(posedge clk_tb);
                #1 pll_lock = 1'b1;
            end else if (lock_mode == 1) begin
                repeat (50) @(posedge clk_tb);
                #1 pll_lock = 1'b1;
                repeat (2) @(posedge clk_tb);
                #1 pll_lock = 1'b0;
                @(posedge clk_tb);
                #1 pll_lock = 1'b1;
            end
        end
    end

    initial begin : monitor
        int   since_acc, since_fall, rst_run, kind;
        logic prev_rst;
        exp_t e;
        since_acc = 0; since_fall = 0; rst_run = 0; prev_rst = 1'b0;
        forever begin
            @(negedge clk_tb);
            since_acc++;
            since_fall++;
            if (pll_rst) rst_run++;
            if (prev_rst && !pll_rst) since_fall = 0;
            prev_rst = pll_rst;
            if (done || err || lock_lost) begin
                kind = {29'd0, lock_lost, err, done};
                if (sb.size() == 0) begin
                    chk("unexpected_event", kind, 0);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", kind, e.kind);
                    chk("dyn_odiv0", int'(dyn_odiv0), e.odiv);
                    chk("dyn_duty0", int'(dyn_duty0), e.duty);
                    chk("dyn_phase0", int'(dyn_phase0), e.phase);
                    if (e.rst_len >= 0) chk("pll_rst_cycles", rst_run, e.rst_len);
                    if (e.lat_src == 1)      chk("lat_from_accept", since_acc, e.lat);
                    else if (e.lat_src == 2) chk("lat_from_rst_fall", since_fall, e.lat);
                end
            end
            if (req_valid && req_ready) begin
                since_acc = 0;
                rst_run   = 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        repeat (3) @(posedge clk_tb);
        #1;
        chk("rst_pll_rst", pll_rst, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_pulses", {done, err, lock_lost}, 0);
        chk("rst_dyn_odiv0", dyn_odiv0, 100);
        chk("rst_dyn_duty0", dyn_duty0, 100);
        chk("rst_dyn_phase0", dyn_phase0, 16);
        rst_n = 1'b1;
        repeat (3) @(posedge clk_tb);

        // Zero divider: rejected, err one cycle after acceptance, no PLL reset.
        push(K_ERR, 100, 100, 16, 0, 1, 1);
        send(0, 50, 3);
        drain();

        // Nominal: 10 reset cycles, lock 50 cycles later, +2 sync, +4 stable.
        lock_mode = 0;
        push(K_DONE, 200, 200, 16, 10, 2, 56);
        send(200, 200, 16);
        chk("busy_in_rst", busy, 1);
        req_valid = 1'b1; req_odiv = '0; req_duty = 10'd999;
        repeat (5) @(posedge clk_tb);
        #1 req_valid = 1'b0;
        drain();

        // Lock drops while idle after a completed reconfiguration.
        @(posedge clk_tb); #1 pll_lock = 1'b0;
        push(K_LOST, 200, 200, 16, -1, 0, 0);
        repeat (10) @(posedge clk_tb);
        #1;
        chk("ready_after_lost", req_ready, 1);
        chk("busy_after_lost", busy, 0);
        drain();

        // Duty above 2*odiv: rejected, settings untouched.
        push(K_ERR, 200, 200, 16, 0, 1, 1);
        send(5, 11, 7);
        drain();

        // Duty exactly 2*odiv accepted; lock glitch restarts the stable count.
        lock_mode = 1;
        push(K_DONE, 5, 10, 8191, 10, 2, 59);
        send(5, 10, 8191);
        drain();

`ifdef PLL_LOCK_TIMEOUT_EN
        // Lock never arrives: err after 100 WAIT_LOCK cycles, new settings kept.
        lock_mode = 2;
        push(K_ERR, 7, 14, 100, 10, 2, 100);
        send(7, 14, 100);
        drain();
        chk("ready_after_timeout", req_ready, 1);
`endif

        // Reset during RST aborts immediately with no pulse.
        lock_mode = 2;
        send(300, 300, 5);
        repeat (3) @(posedge clk_tb);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_pll_rst", pll_rst, 0);
        chk("abort_busy", busy, 0);
        chk("abort_dyn_odiv0", dyn_odiv0, 100);
        chk("abort_dyn_duty0", dyn_duty0, 100);
        chk("abort_dyn_phase0", dyn_phase0, 16);
        @(posedge clk_tb); #1 rst_n = 1'b1;
        repeat (30) @(posedge clk_tb);
        chk("no_event_after_abort", sb.size(), 0);
        chk("idle_after_abort", req_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
